// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one memory/MIO port between the SCPU data port (0) and a debug/DMA port (1).
// Fixed CPU priority with a fairness cap, three-state access FSM, per-port one-cycle ready pulse.
module mio_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int FAIR_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              dbg_ready_q, dbg_ready_d;
    logic [3:0]        fair_cnt_q, fair_cnt_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              dbg_win;

    // The debug port only overtakes a requesting CPU once the CPU has used up its streak.
    assign dbg_win = dbg_req && (!cpu_req || fair_cnt_q == 4'(FAIR_MAX));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        fair_cnt_d  = fair_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        mem_en_d    = 1'b0;
        cpu_ready_d = 1'b0;
        dbg_ready_d = 1'b0;
        case (state_q)
            IDLE: if (cpu_req || dbg_req) begin
                state_d    = ACCESS;
                owner_d    = dbg_win;
                we_d       = dbg_win ? dbg_we : cpu_we;
                addr_d     = dbg_win ? dbg_addr : cpu_addr;
                wdata_d    = dbg_win ? dbg_wdata : cpu_wdata;
                lat_cnt_d  = 4'(MEM_LAT);
                mem_en_d   = 1'b1;
                fair_cnt_d = (dbg_win || !dbg_req) ? 4'd0 :
                             (fair_cnt_q == 4'(FAIR_MAX)) ? fair_cnt_q : fair_cnt_q + 4'd1;
            end
            ACCESS: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d     = DONE;
                    rdata_d     = we_q ? rdata_q : mem_rdata;
                    cpu_ready_d = !owner_q;
                    dbg_ready_d = owner_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            fair_cnt_q  <= 4'd0;
            lat_cnt_q   <= 4'd0;
            mem_en_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            fair_cnt_q  <= fair_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_en_q    <= mem_en_d;
            cpu_ready_q <= cpu_ready_d;
            dbg_ready_q <= dbg_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_en_q && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dbg_ready = dbg_ready_q;
    assign cpu_rdata = cpu_ready_q ? rdata_q : '0;
    assign dbg_rdata = dbg_ready_q ? rdata_q : '0;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: random and directed traffic on both ports, checked by a queue scoreboard
// fed from a cycle-level arbitration model.
module tb_mio_bus_arbiter;
    localparam int LAT  = 3;
    localparam int FAIR = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dbg_ready, mem_en, mem_we, busy;

    mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .FAIR_MAX(FAIR)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          g;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    int          streak = 0;
    int          next_arb = 0;
    logic [31:0] last_read = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " cpu_ready"}, 32'(cpu_ready), 0);
        chk({nm, " dbg_ready"}, 32'(dbg_ready), 0);
        chk({nm, " cpu_rdata"}, cpu_rdata, 0);
        chk({nm, " dbg_rdata"}, dbg_rdata, 0);
        chk({nm, " mem_en"}, 32'(mem_en), 0);
        chk({nm, " mem_we"}, 32'(mem_we), 0);
        chk({nm, " mem_addr"}, mem_addr, 0);
        chk({nm, " mem_wdata"}, mem_wdata, 0);
        chk({nm, " busy"}, 32'(busy), 0);
    endtask

    // Reference arbitration: one grant per free slot, each access blocks the bus for LAT+2 cycles.
    initial forever begin
        exp_t e;
        bit   dw;
        @(posedge clk);
        cyc++;
        if (rst) begin
            sb.delete();
            streak    = 0;
            next_arb  = 0;
            last_read = '0;
            continue;
        end
        if (cyc >= next_arb && (cpu_req || dbg_req)) begin
            dw = dbg_req && (!cpu_req || streak >= FAIR);
            streak  = dw || !dbg_req ? 0 : (streak < FAIR ? streak + 1 : streak);
            e.port  = dw;
            e.we    = dw ? dbg_we : cpu_we;
            e.addr  = dw ? dbg_addr : cpu_addr;
            e.wdata = dw ? dbg_wdata : cpu_wdata;
            e.g     = cyc;
            sb.push_back(e);
            next_arb = cyc + LAT + 2;
        end
    end

    // Memory returns garbage until LAT-1 cycles after the strobe cycle.
    initial begin
        int k = 100;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            k = mem_en ? 0 : k + 1;
            mem_rdata = (k >= LAT - 1) ? memf(mem_addr) : (32'hBAD00000 | 32'(k));
        end
    end

    initial forever begin
        exp_t        e;
        bit          has, en_x, rdy_x;
        logic [31:0] rd_x;
        @(negedge clk);
        if (rst) continue;
        has = sb.size() > 0;
        if (has) e = sb[0];
        en_x  = has && cyc == e.g;
        rdy_x = has && cyc == e.g + LAT;
        rd_x  = '0;
        chk("busy", 32'(busy), 32'(has && cyc <= e.g + LAT));
        chk("mem_en", 32'(mem_en), 32'(en_x));
        if (en_x && mem_en) begin
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
        end
        if (rdy_x) begin
            rd_x = e.we ? last_read : memf(e.addr);
            if (!e.we) last_read = rd_x;
            void'(sb.pop_front());
        end
        chk("cpu_ready", 32'(cpu_ready), 32'(rdy_x && !e.port));
        chk("dbg_ready", 32'(dbg_ready), 32'(rdy_x && e.port));
        chk("cpu_rdata", cpu_rdata, (rdy_x && !e.port) ? rd_x : 32'h0);
        chk("dbg_rdata", dbg_rdata, (rdy_x && e.port) ? rd_x : 32'h0);
    end

    task automatic port_xfer(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                             input bit keep);
        int n = 0;
        bit rdy;
        if (!p) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end
        do begin
            @(negedge clk);
            n++;
            rdy = p ? dbg_ready : cpu_ready;
        end while (!rdy && n < 200);
        checks++;
        if (!rdy) begin
            fails++;
            $display("FAIL timeout port %0d: no ready after %0d cycles, required within 200", p, n);
        end
        if (!keep) begin
            if (!p) cpu_req = 1'b0;
            else dbg_req = 1'b0;
        end
    endtask

    task automatic rand_port(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 3);
            port_xfer(p, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, gap == 0);
            repeat (gap) @(negedge clk);
        end
        if (!p) cpu_req = 1'b0;
        else dbg_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required to end within 500000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        #2 rst = 1'b0;
        @(negedge clk);
        port_xfer(0, 0, 32'h10, 32'h0, 0);
        port_xfer(0, 1, 32'h20, 32'h12345678, 0);
        repeat (2) @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("midrst");
        cpu_req = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        port_xfer(0, 0, 32'h44, 32'h0, 0);
        fork
            for (int i = 0; i < 10; i++) port_xfer(0, 0, 32'h100 + 32'(i * 4), 32'h0, 1);
            for (int i = 0; i < 2; i++) port_xfer(1, 1, 32'h200 + 32'(i * 4), 32'hCAFE0000 + 32'(i), 1);
        join
        cpu_req = 0; dbg_req = 0;
        repeat (3) @(negedge clk);
        fork
            port_xfer(1, 0, 32'h300, 32'h0, 0);
            begin
                repeat (2) @(negedge clk);
                port_xfer(0, 0, 32'h304, 32'h0, 0);
            end
        join
        for (int i = 0; i < 4; i++) port_xfer(0, 0, 32'h400 + 32'(i * 4), 32'h0, 1);
        cpu_req = 0;
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        repeat (LAT + 4) @(negedge clk);
        chk("drain", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
